instruction_cache: RTL
======================

# instruction_cache

Direct-mapped, read-only instruction cache sitting between the CPU fetch port and the word-addressed-by-block instruction memory. It responds to the CPU's PC-driven fetch requests: it returns a 32-bit instruction on a hit and stalls the CPU with `busywait` while it refills a 16-byte block from instruction memory on a miss. It replaces the direct PC-to-`instr_mem` byte lookup used so far.

## Interface
- `NUM_BLOCKS`, 8, cache lines; power of two.
- `ADDR_W`, 10, CPU byte-address width (1 KB instruction space).
- `CLK` in 1: rising-edge clock.
- `RESET` in 1: synchronous, active-high reset. One clock, `CLK`; reset is synchronous and active-high.
- `address` in `ADDR_W`: fetch byte address (PC[9:0]). Bits [1:0] are ignored.
- `readdata` out 32: instruction word, valid whenever `busywait`=0.
- `busywait` out 1: stall request to the CPU.
- `mem_read` out 1: block read request to instruction memory.
- `mem_address` out 6: block address {tag,index}.
- `mem_readdata` in 128: refilled block, little-endian words (word0 = bits [31:0]).
- `mem_busywait` in 1: memory busy; data valid on the first cycle it is low with `mem_read` high.

## Operation
- Address split: tag [9:7], index [6:4], word offset [3:2].
- Storage per line: valid bit, 3-bit tag, 128-bit data.
- Hit = valid[index] && tag match. `readdata` is selected combinationally from data[index] by offset.
- FSM states:
  - IDLE
    - hit: `busywait`=0.
    - miss: `busywait`=1; next edge goes to MEM_READ.
  - MEM_READ
    - `mem_read`=1; `mem_address`={tag,index} taken from the current `address`.
    - `busywait`=1.
    - Goes to UPDATE on the edge where `mem_busywait`=0.
  - UPDATE
    - On the edge leaving UPDATE: write `mem_readdata` (registered at MEM_READ exit), the tag, and valid=1 into the line.
    - `busywait`=1; `mem_read`=0; next state is IDLE.
- The CPU holds PC while `busywait`=1. If `address` nevertheless changes during MEM_READ, `mem_address` stays latched at MEM_READ entry, the fill completes, and the address is re-evaluated in IDLE, possibly causing a second miss.
- Reset values:
  - state=IDLE, all valid bits 0, `mem_read`=0, `mem_address`=0.
  - `busywait`=0 while `RESET`=1.
  - Data and tag arrays are not reset.
- Reset during MEM_READ or UPDATE aborts the fill. `mem_read` drops after the reset edge and no line is written.

## Timing
- Hit: zero-cycle. `readdata` is valid in the same cycle `address` settles.
- Miss from IDLE, cycle by cycle:
  - Cycle 0: miss detected, `busywait`=1.
  - Cycle 1: MEM_READ.
  - MEM_READ lasts N+1 cycles for a memory that holds `mem_busywait` high for N cycles.
  - Then 1 cycle in UPDATE.
  - The next cycle is IDLE with a hit; `busywait` falls there.
- Total stall = N+3 cycles.
- `mem_read` is registered. It is never high for more than one request per fill.
- `mem_busywait` is sampled only in MEM_READ.

## Configuration
- `ICACHE_STATS_EN` defined: adds two 16-bit outputs, `hit_count` and `miss_count`.
  - `hit_count` increments on each edge in IDLE with a hit and `RESET`=0.
  - `miss_count` increments on each IDLE→MEM_READ transition.
  - Both saturate at 16'hFFFF and clear on `RESET`.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- `icache_pkg` holds:
  - the state enum (IDLE, MEM_READ, UPDATE)
  - TAG_W=3, INDEX_W=3, OFFSET_W=2, BLOCK_W=128
  - the address-field slice constants.
- One natural sub-module, `icache_line_array`:
  - valid, tag and data storage
  - synchronous write port and synchronous valid clear
  - combinational read of tag, valid and data by index.
- The FSM, hit compare and word mux live in `instruction_cache`.

## Test plan
- Reset, then `address`=0x000 with the memory model at N=5: `busywait` is high for 8 cycles, `mem_read` pulses with `mem_address`=0, then `readdata`=word0 of block 0 (0x00000009 for the loadi program).
- After the fill, step `address` through 0x004, 0x008, 0x00C: each is a hit, `busywait`=0, `readdata` = words 1–3 of block 0, and there is no `mem_read`.
- Conflict: `address`=0x080 (tag 1, index 0) after block 0 is loaded → miss with `mem_address`=0x08, line replaced; return to 0x000 → miss again.
- Assert `RESET` for 1 cycle during MEM_READ: `mem_read`=0 the next cycle, state IDLE, and re-fetching 0x000 misses.
- Change `address` from 0x010 to 0x020 mid-fill: `mem_address` stays 0x01; after UPDATE a second miss is issued with `mem_address`=0x02.
- With `ICACHE_STATS_EN` defined, run 10 sequential fetches from 0x000: `miss_count`=3, `hit_count`≥7; counters clear on reset.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants, address-field positions and FSM state type for the instruction cache.
package icache_pkg;

   localparam int TAG_W      = 3;
   localparam int INDEX_W    = 3;
   localparam int OFFSET_W   = 2;
   localparam int BLOCK_W    = 128;
   localparam int WORD_W     = 32;

   // Byte-address field positions: tag [9:7], index [6:4], word offset [3:2]
   localparam int OFFSET_LSB = 2;
   localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
   localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } icache_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: one synchronous write port,
// synchronous clear of all valid bits, combinational read by index.
module icache_line_array
   import icache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               write_en,
   input  logic [INDEX_W-1:0] write_index,
   input  logic [TAG_W-1:0]   write_tag,
   input  logic [BLOCK_W-1:0] write_data,
   input  logic [INDEX_W-1:0] read_index,
   output logic               read_valid,
   output logic [TAG_W-1:0]   read_tag,
   output logic [BLOCK_W-1:0] read_data
);

   logic [NUM_BLOCKS-1:0] valid;
   logic [TAG_W-1:0]      tags [NUM_BLOCKS];
   logic [BLOCK_W-1:0]    data [NUM_BLOCKS];

   always_ff @(posedge clk) begin
      if (clear) begin
         valid <= '0;
      end else if (write_en) begin
         valid[write_index] <= 1'b1;
      end
   end

   // Tag and data are deliberately left unreset; valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (write_en && !clear) begin
         tags[write_index] <= write_tag;
         data[write_index] <= write_data;
      end
   end

   assign read_valid = valid[read_index];
   assign read_tag   = tags[read_index];
   assign read_data  = data[read_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with a 16-byte block refill FSM.
// Define ICACHE_STATS_EN to add saturating 16-bit hit_count / miss_count outputs.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | serving fetches; a hit returns data this cycle, a miss stalls
// MEM_READ | mem_read held high until memory drops mem_busywait
// UPDATE   | captured block, tag and valid are written into the line
module instruction_cache
   import icache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8,
   parameter int ADDR_W     = 10
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [ADDR_W-1:0]        address,
   output logic [WORD_W-1:0]        readdata,
   output logic                     busywait,
   output logic                     mem_read,
   output logic [TAG_W+INDEX_W-1:0] mem_address,
   input  logic [BLOCK_W-1:0]       mem_readdata,
   input  logic                     mem_busywait
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0]              hit_count,
   output logic [15:0]              miss_count
`endif
);

   icache_state_e        state;
   icache_state_e        state_nxt;
   logic [TAG_W-1:0]     tag;
   logic [INDEX_W-1:0]   index;
   logic [OFFSET_W-1:0]  offset;
   logic                 line_valid;
   logic [TAG_W-1:0]     line_tag;
   logic [BLOCK_W-1:0]   line_data;
   logic [BLOCK_W-1:0]   fill_data;
   logic                 hit;
   logic                 line_write;
   logic [1:0]           unused_addr;

   assign tag         = address[TAG_LSB +: TAG_W];
   assign index       = address[INDEX_LSB +: INDEX_W];
   assign offset      = address[OFFSET_LSB +: OFFSET_W];
   assign unused_addr = address[1:0];

   icache_line_array #(
      .NUM_BLOCKS (NUM_BLOCKS)
   ) u_lines (
      .clk         (CLK),
      .clear       (RESET),
      .write_en    (line_write),
      .write_index (mem_address[INDEX_W-1:0]),
      .write_tag   (mem_address[INDEX_W +: TAG_W]),
      .write_data  (fill_data),
      .read_index  (index),
      .read_valid  (line_valid),
      .read_tag    (line_tag),
      .read_data   (line_data)
   );

   assign hit        = line_valid && (line_tag == tag);
   assign busywait   = !RESET && ((state != IDLE) || !hit);
   assign line_write = (state == UPDATE) && !RESET;

   always_comb begin
      readdata = line_data[31:0];
      case (offset)
         2'd0: readdata = line_data[31:0];
         2'd1: readdata = line_data[63:32];
         2'd2: readdata = line_data[95:64];
         2'd3: readdata = line_data[127:96];
         default: readdata = line_data[31:0];
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (!hit) state_nxt = MEM_READ;
         MEM_READ: if (!mem_busywait) state_nxt = UPDATE;
         UPDATE:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // The refill block address is latched on entry to MEM_READ so a wandering
   // PC cannot redirect a fill that is already in flight.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= IDLE;
         mem_read    <= 1'b0;
         mem_address <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && !hit) begin
            mem_read    <= 1'b1;
            mem_address <= {tag, index};
         end else if (state == MEM_READ && !mem_busywait) begin
            mem_read    <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (state == MEM_READ && !mem_busywait) begin
         fill_data <= mem_readdata;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == IDLE) begin
         if (hit && hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
         end
         if (!hit && miss_count != 16'hFFFF) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif

endmodule
